// File: rtl/max_arb_pkg.sv
// Shared types and constants for the two-requester find_MAX sequencer.
// The instruction encodings are common to the sequencer and the datapath.
package max_arb_pkg;

   localparam int DEF_DW = 8;
   localparam int DEF_IW = 3;
   localparam int DEF_LW = 4;
   localparam int DEF_TW = 8;

   localparam logic [DEF_IW-1:0] INSTR_MAX     = 3'd0;
   localparam logic [DEF_IW-1:0] INSTR_MIN     = 3'd1;
   localparam logic [DEF_IW-1:0] INSTR_MAX_ABS = 3'd2;
   localparam logic [DEF_IW-1:0] INSTR_MIN_ABS = 3'd3;
   localparam logic [DEF_IW-1:0] INSTR_PASS_A  = 3'd4;
   localparam logic [DEF_IW-1:0] INSTR_PASS_B  = 3'd5;

   typedef enum logic [3:0] {
      S_IDLE,
      S_START,
      S_STREAM,
      S_FWD,
      S_ONE_LEFT,
      S_LAST,
      S_FWD_LAST,
      S_WAIT_FIN,
      S_DONE
   } state_t;

   // States in which the owner may hand over an operand pair.
   function automatic logic accepts_pair(input state_t s);
      return (s == S_STREAM) || (s == S_LAST);
   endfunction

   function automatic logic forwards_pair(input state_t s);
      return (s == S_FWD) || (s == S_FWD_LAST);
   endfunction

endpackage

// File: rtl/max_job_arbiter_rr.sv
// Two-input round-robin arbiter with a registered last-served pointer.
// The pointer only moves when the sequencer finishes a job.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       served,
   output logic       pick,
   output logic       any
);

   logic last;

   // Reset to "1 served last" so requester 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= 1'b1;
      end else if (update) begin
         last <= served;
      end
   end

   always_comb begin
      any  = |req;
      pick = 1'b0;
      case (req)
         2'b01:   pick = 1'b0;
         2'b10:   pick = 1'b1;
         2'b11:   pick = ~last;
         default: pick = 1'b0;
      endcase
   end

endmodule

// File: rtl/max_job_arbiter.sv
// Job sequencer sharing one find_MAX datapath between two requesters:
// grants a job, streams its pairs with one_left before the last, returns the maximum.
module max_job_arbiter
   import max_arb_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int IW = DEF_IW,
   parameter int LW = DEF_LW,
   parameter int TW = DEF_TW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          req1,
   input  logic [LW-1:0] len0,
   input  logic [LW-1:0] len1,
   input  logic          pvalid0,
   input  logic          pvalid1,
   input  logic [DW-1:0] pa0,
   input  logic [DW-1:0] pa1,
   input  logic [DW-1:0] pb0,
   input  logic [DW-1:0] pb1,
   input  logic [IW-1:0] pinstr0,
   input  logic [IW-1:0] pinstr1,
   output logic          pready0,
   output logic          pready1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          done0,
   output logic          done1,
   output logic [DW-1:0] result,
   output logic          err,
   output logic          dp_start,
   output logic          dp_valid,
   output logic          dp_one_left,
   output logic [DW-1:0] dp_a,
   output logic [DW-1:0] dp_b,
   output logic [IW-1:0] dp_instr,
   input  logic [DW-1:0] dp_maximum,
   input  logic          dp_finish
);

   localparam logic [LW-1:0] LEN_ONE  = LW'(1);
   localparam logic [TW-1:0] TIM_ONE  = TW'(1);
   localparam logic [TW-1:0] TIM_LAST = {{(TW-1){1'b1}}, 1'b0};

   state_t        state;
   logic          owner;
   logic [LW-1:0] remaining;
   logic [TW-1:0] timer;

   logic          arb_pick;
   logic          arb_any;
   logic [LW-1:0] pick_len;
   logic          own_pvalid;
   logic [DW-1:0] own_pa;
   logic [DW-1:0] own_pb;
   logic [IW-1:0] own_pinstr;
   logic          busy;
   logic          accepting;
   logic          handshake;

   rr_arbiter2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    ({req1, req0}),
      .update (state == S_DONE),
      .served (owner),
      .pick   (arb_pick),
      .any    (arb_any)
   );

   assign pick_len   = arb_pick ? len1 : len0;
   assign own_pvalid = owner ? pvalid1 : pvalid0;
   assign own_pa     = owner ? pa1 : pa0;
   assign own_pb     = owner ? pb1 : pb0;
   assign own_pinstr = owner ? pinstr1 : pinstr0;

   assign busy      = (state != S_IDLE);
   assign accepting = accepts_pair(state);
   assign handshake = accepting & own_pvalid;

   assign gnt0        = busy & ~owner;
   assign gnt1        = busy & owner;
   assign pready0     = accepting & ~owner;
   assign pready1     = accepting & owner;
   assign done0       = (state == S_DONE) & ~owner;
   assign done1       = (state == S_DONE) & owner;
   assign dp_start    = (state == S_START);
   assign dp_valid    = forwards_pair(state);
   assign dp_one_left = (state == S_ONE_LEFT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         owner     <= 1'b0;
         remaining <= '0;
         timer     <= '0;
         dp_a      <= '0;
         dp_b      <= '0;
         dp_instr  <= '0;
         result    <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (arb_any) begin
                  owner <= arb_pick;
                  // A zero length still carries one pair.
                  remaining <= (pick_len == '0) ? LEN_ONE : pick_len;
                  state     <= S_START;
               end
            end
            S_START: begin
               state <= (remaining == LEN_ONE) ? S_ONE_LEFT : S_STREAM;
            end
            S_STREAM: begin
               if (handshake) begin
                  dp_a      <= own_pa;
                  dp_b      <= own_pb;
                  dp_instr  <= own_pinstr;
                  remaining <= remaining - LEN_ONE;
                  state     <= S_FWD;
               end
            end
            S_FWD: begin
               state <= (remaining == LEN_ONE) ? S_ONE_LEFT : S_STREAM;
            end
            S_ONE_LEFT: begin
               state <= S_LAST;
            end
            S_LAST: begin
               if (handshake) begin
                  dp_a     <= own_pa;
                  dp_b     <= own_pb;
                  dp_instr <= own_pinstr;
                  state    <= S_FWD_LAST;
               end
            end
            S_FWD_LAST: begin
               timer <= '0;
               state <= S_WAIT_FIN;
            end
            S_WAIT_FIN: begin
               timer <= timer + TIM_ONE;
               // Finish wins over a timeout landing in the same cycle.
               if (dp_finish) begin
                  result <= dp_maximum;
                  err    <= 1'b0;
                  state  <= S_DONE;
               end else if (timer == TIM_LAST) begin
                  result <= '0;
                  err    <= 1'b1;
                  state  <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_max_job_arbiter.sv
// Scoreboard bench for max_job_arbiter: directed jobs push expected events,
// a monitor pops and compares them as the DUT presents start/valid/one_left/done.
module tb_max_job_arbiter;

   localparam int DW = 8;
   localparam int IW = 3;
   localparam int LW = 4;
   localparam int TW = 8;

   localparam int EV_START = 0;
   localparam int EV_VALID = 1;
   localparam int EV_OL    = 2;
   localparam int EV_DONE  = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0 = 1'b0, req1 = 1'b0;
   logic [LW-1:0] len0 = '0, len1 = '0;
   logic          pvalid0 = 1'b0, pvalid1 = 1'b0;
   logic [DW-1:0] pa0 = '0, pa1 = '0, pb0 = '0, pb1 = '0;
   logic [IW-1:0] pinstr0 = '0, pinstr1 = '0;
   logic          pready0, pready1, gnt0, gnt1, done0, done1;
   logic [DW-1:0] result;
   logic          err;
   logic          dp_start, dp_valid, dp_one_left;
   logic [DW-1:0] dp_a, dp_b;
   logic [IW-1:0] dp_instr;
   logic [DW-1:0] dp_maximum = '0;
   logic          dp_finish = 1'b0;

   max_job_arbiter #(.DW(DW), .IW(IW), .LW(LW), .TW(TW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .len0(len0), .len1(len1),
      .pvalid0(pvalid0), .pvalid1(pvalid1),
      .pa0(pa0), .pa1(pa1), .pb0(pb0), .pb1(pb1),
      .pinstr0(pinstr0), .pinstr1(pinstr1),
      .pready0(pready0), .pready1(pready1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .result(result), .err(err),
      .dp_start(dp_start), .dp_valid(dp_valid), .dp_one_left(dp_one_left),
      .dp_a(dp_a), .dp_b(dp_b), .dp_instr(dp_instr),
      .dp_maximum(dp_maximum), .dp_finish(dp_finish)
   );

   always #5 clk = ~clk;

   typedef struct {
      int             kind;
      logic [DW-1:0]  a;
      logic [DW-1:0]  b;
      logic [IW-1:0]  ins;
      int             owner;
      logic [DW-1:0]  res;
      logic           e;
      int             gap;
   } ev_t;

   ev_t           expq[$];
   logic [DW-1:0] st_a[$], st_b[$];
   logic [IW-1:0] st_i[$];
   logic [DW-1:0] qa[2][$], qb[2][$];
   logic [IW-1:0] qi[2][$];
   int            jl[2][$], jn[2][$];

   int   compared = 0;
   int   mismatched = 0;
   int   cyc = 0;
   int   last_valid_cyc = 0;
   int   gnt1_cycles = 0;
   logic prev_valid = 1'b0;
   bit   fin_en = 1'b1;
   bit   spur = 1'b0;
   bit   abort = 1'b0;
   logic [DW-1:0] run_max = '0;
   bit   seen_ol = 1'b0;
   int   cd = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [12:0] ctrl_vec();
      return {gnt0, gnt1, done0, done1, pready0, pready1, err,
              dp_start, dp_valid, dp_one_left, dp_instr};
   endfunction

   function automatic logic pready_of(input int id);
      return (id == 0) ? pready0 : pready1;
   endfunction

   function automatic logic gnt_of(input int id);
      return (id == 0) ? gnt0 : gnt1;
   endfunction

   function automatic logic done_of(input int id);
      return (id == 0) ? done0 : done1;
   endfunction

   task automatic push_ev(input int kind, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [IW-1:0] ins, input int owner,
                          input logic [DW-1:0] res, input logic e, input int gap);
      ev_t ev;
      ev.kind = kind; ev.a = a; ev.b = b; ev.ins = ins;
      ev.owner = owner; ev.res = res; ev.e = e; ev.gap = gap;
      expq.push_back(ev);
   endtask

   task automatic pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [IW-1:0] ins);
      st_a.push_back(a); st_b.push_back(b); st_i.push_back(ins);
   endtask

   // Expected order: start, pairs with one_left ahead of the last one, done.
   task automatic plan_job(input int id, input int len_field, input logic [DW-1:0] res,
                           input logic e, input int gap);
      int n;
      n = st_a.size();
      push_ev(EV_START, 0, 0, 0, id, 0, 0, 0);
      for (int i = 0; i < n; i++) begin
         if (i == n - 1) push_ev(EV_OL, 0, 0, 0, id, 0, 0, 0);
         push_ev(EV_VALID, st_a[i], st_b[i], st_i[i], id, 0, 0, 0);
         qa[id].push_back(st_a[i]); qb[id].push_back(st_b[i]); qi[id].push_back(st_i[i]);
      end
      push_ev(EV_DONE, 0, 0, 0, id, res, e, gap);
      jl[id].push_back(len_field);
      jn[id].push_back(n);
      st_a.delete(); st_b.delete(); st_i.delete();
   endtask

   task automatic set_req(input int id, input logic v, input int l);
      if (id == 0) begin req0 = v; if (v) len0 = LW'(l); end
      else         begin req1 = v; if (v) len1 = LW'(l); end
   endtask

   task automatic set_pv(input int id, input logic v, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [IW-1:0] ins);
      if (id == 0) begin pvalid0 = v; pa0 = a; pb0 = b; pinstr0 = ins; end
      else         begin pvalid1 = v; pa1 = a; pb1 = b; pinstr1 = ins; end
   endtask

   task automatic drive_pair(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [IW-1:0] ins);
      int cnt;
      cnt = 0;
      set_pv(id, 1'b1, a, b, ins);
      while (!pready_of(id) && !abort && cnt < 1000) begin
         @(negedge clk);
         cnt++;
      end
      chk("pready_wait_bound", cnt < 1000, 1);
      if (!abort) @(negedge clk);
      set_pv(id, 1'b0, a, b, ins);
   endtask

   task automatic run_jobs(input int id, input int njobs, input int stall_at, input int stall_len);
      int lf, np, cnt;
      for (int j = 0; j < njobs; j++) begin
         lf = jl[id].pop_front();
         np = jn[id].pop_front();
         if (abort) return;
         set_req(id, 1'b1, lf);
         cnt = 0;
         do begin
            @(negedge clk);
            cnt++;
         end while (!gnt_of(id) && !abort && cnt < 3000);
         chk("gnt_wait_bound", cnt < 3000, 1);
         set_req(id, 1'b0, lf);
         for (int p = 0; p < np; p++) begin
            logic [DW-1:0] a, b;
            logic [IW-1:0] ins;
            a = qa[id].pop_front(); b = qb[id].pop_front(); ins = qi[id].pop_front();
            if (abort) break;
            if (p == stall_at) begin
               repeat (stall_len) @(negedge clk);
               chk("stall_holds_stream", pready_of(id), 1);
            end
            drive_pair(id, a, b, ins);
         end
         cnt = 0;
         do begin
            @(negedge clk);
            cnt++;
         end while (!done_of(id) && !abort && cnt < 1000);
         chk("done_wait_bound", cnt < 1000, 1);
      end
   endtask

   // find_MAX stand-in: tracks the running max and finishes 3 cycles after the final pair.
   initial begin
      forever begin
         @(negedge clk);
         dp_finish = 1'b0;
         if (!rst_n) begin
            cd = 0; seen_ol = 1'b0; run_max = '0;
         end else begin
            if (cd > 0) begin
               cd--;
               if (cd == 0 && fin_en) begin
                  dp_finish = 1'b1;
                  dp_maximum = run_max;
               end
            end
            if (spur && (pready0 || pready1)) begin
               dp_finish = 1'b1;
               dp_maximum = 8'hFF;
               spur = 1'b0;
            end
            if (dp_start) begin run_max = '0; seen_ol = 1'b0; end
            if (dp_one_left) seen_ol = 1'b1;
            if (dp_valid) begin
               if (dp_a > run_max) run_max = dp_a;
               if (dp_b > run_max) run_max = dp_b;
               if (seen_ol) cd = 3;
            end
         end
      end
   end

   initial begin
      int nk, k;
      ev_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            prev_valid = 1'b0;
         end else begin
            if (gnt0 || gnt1) chk("gnt_exclusive", gnt0 & gnt1, 0);
            if (gnt1) gnt1_cycles++;
            nk = int'(dp_start) + int'(dp_valid) + int'(dp_one_left) + int'(done0) + int'(done1);
            if (nk > 1) chk("events_per_cycle", nk, 1);
            if (dp_valid) chk("valid_isolated", prev_valid, 0);
            if (nk > 0) begin
               k = dp_start ? EV_START : dp_valid ? EV_VALID : dp_one_left ? EV_OL : EV_DONE;
               chk("event_expected", expq.size() > 0, 1);
               if (expq.size() > 0) begin
                  e = expq.pop_front();
                  chk("event_kind", k, e.kind);
                  if (k == e.kind) begin
                     case (k)
                        EV_START: begin
                           chk("start_gnt0", gnt0, e.owner == 0);
                           chk("start_gnt1", gnt1, e.owner == 1);
                        end
                        EV_VALID: begin
                           chk("dp_a", dp_a, e.a);
                           chk("dp_b", dp_b, e.b);
                           chk("dp_instr", dp_instr, e.ins);
                        end
                        EV_DONE: begin
                           chk("done0", done0, e.owner == 0);
                           chk("done1", done1, e.owner == 1);
                           chk("result", result, e.res);
                           chk("err", err, e.e);
                           chk("last_valid_to_done", cyc - last_valid_cyc, e.gap);
                        end
                        default: ;
                     endcase
                  end
               end
            end
            if (dp_valid) last_valid_cyc = cyc;
            prev_valid = dp_valid;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time limit (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int g1, nv, cnt;
      repeat (3) @(negedge clk);
      chk("reset_ctrl", ctrl_vec(), 0);
      chk("reset_data", {result, dp_a, dp_b}, 0);
      rst_n = 1'b1;

      // Contention: both requesters keep requesting, service must alternate.
      pair(8'h01, 8'h05, 3'd0); pair(8'h03, 8'h02, 3'd1); plan_job(0, 2, 8'h05, 1'b0, 4);
      pair(8'h10, 8'h20, 3'd2); pair(8'h30, 8'h0F, 3'd3); plan_job(1, 2, 8'h30, 1'b0, 4);
      pair(8'h44, 8'h43, 3'd4); pair(8'h42, 8'h41, 3'd5); plan_job(0, 2, 8'h44, 1'b0, 4);
      pair(8'h7F, 8'h80, 3'd6); pair(8'h00, 8'h01, 3'd7); plan_job(1, 2, 8'h80, 1'b0, 4);
      pair(8'hFF, 8'h00, 3'd0); pair(8'h10, 8'h10, 3'd1); plan_job(0, 2, 8'hFF, 1'b0, 4);
      pair(8'h08, 8'h09, 3'd2); pair(8'h0A, 8'h0B, 3'd3); plan_job(1, 2, 8'h0B, 1'b0, 4);
      fork
         run_jobs(0, 3, -1, 0);
         run_jobs(1, 3, -1, 0);
      join

      // Single four-pair job from requester 0.
      @(negedge clk); #1;
      g1 = gnt1_cycles;
      pair(8'h12, 8'h34, 3'd0); pair(8'h56, 8'h78, 3'd1);
      pair(8'h9A, 8'h11, 3'd2); pair(8'h22, 8'h33, 3'd3);
      plan_job(0, 4, 8'h9A, 1'b0, 4);
      run_jobs(0, 1, -1, 0);
      chk("gnt1_idle_single", gnt1_cycles - g1, 0);

      // Short jobs: len 1 and len 0.
      @(negedge clk); #1;
      pair(8'hAB, 8'hCD, 3'd5); plan_job(0, 1, 8'hCD, 1'b0, 4);
      run_jobs(0, 1, -1, 0);
      @(negedge clk); #1;
      pair(8'h5A, 8'hA5, 3'd6); plan_job(1, 0, 8'hA5, 1'b0, 4);
      run_jobs(1, 1, -1, 0);

      // Timeout, then a normal job.
      @(negedge clk); #1;
      fin_en = 1'b0;
      pair(8'h11, 8'h22, 3'd0); pair(8'h33, 8'h44, 3'd1); plan_job(0, 2, 8'h00, 1'b1, 256);
      run_jobs(0, 1, -1, 0);
      fin_en = 1'b1;
      @(negedge clk); #1;
      pair(8'h01, 8'h02, 3'd2); pair(8'h03, 8'h04, 3'd3); plan_job(1, 2, 8'h04, 1'b0, 4);
      run_jobs(1, 1, -1, 0);

      // Spurious finish in STREAM and a 10-cycle owner stall.
      @(negedge clk); #1;
      spur = 1'b1;
      pair(8'h20, 8'h21, 3'd4); pair(8'h22, 8'h23, 3'd5); pair(8'h24, 8'h25, 3'd6);
      plan_job(0, 3, 8'h25, 1'b0, 4);
      run_jobs(0, 1, 1, 10);
      chk("spurious_issued", spur, 0);

      // Reset after the second forwarded pair of a four-pair job.
      @(negedge clk); #1;
      push_ev(EV_START, 0, 0, 0, 0, 0, 0, 0);
      push_ev(EV_VALID, 8'h31, 8'h32, 3'd1, 0, 0, 0, 0);
      push_ev(EV_VALID, 8'h33, 8'h34, 3'd2, 0, 0, 0, 0);
      qa[0] = '{8'h31, 8'h33, 8'h35, 8'h37};
      qb[0] = '{8'h32, 8'h34, 8'h36, 8'h38};
      qi[0] = '{3'd1, 3'd2, 3'd3, 3'd4};
      jl[0].push_back(4); jn[0].push_back(4);
      fork
         run_jobs(0, 1, -1, 0);
         begin
            nv = 0; cnt = 0;
            while (nv < 2 && cnt < 500) begin
               @(negedge clk);
               cnt++;
               if (dp_valid) nv++;
            end
            chk("reset_reach_second_valid", nv, 2);
            #2;
            rst_n = 1'b0;
            abort = 1'b1;
            #1;
            chk("midjob_reset_ctrl", ctrl_vec(), 0);
            chk("midjob_reset_data", {result, dp_a, dp_b}, 0);
            chk("midjob_queue_drained", expq.size(), 0);
         end
      join
      qa[0].delete(); qb[0].delete(); qi[0].delete();
      repeat (3) @(negedge clk);
      chk("held_reset_ctrl", ctrl_vec(), 0);
      rst_n = 1'b1;
      abort = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      pair(8'h0A, 8'h0B, 3'd7); pair(8'h0C, 8'h0D, 3'd0); plan_job(0, 2, 8'h0D, 1'b0, 4);
      run_jobs(0, 1, -1, 0);

      cnt = 0;
      while (expq.size() > 0 && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      repeat (5) @(negedge clk);
      chk("final_queue_empty", expq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
